// File: rtl/disp_pkg.sv
// Shared definitions for the clock-display mode controller.
// - disp_state_e : view/set state encoding (also driven out on the debug mode port)
// - DEF_*        : default timing constants, all in 1 kHz clock cycles (ms)
// - is_set_state : true for the two time-adjust states
package disp_pkg;

  typedef enum logic [1:0] {
    CLOCK     = 2'd0,
    STOPWATCH = 2'd1,
    SET_HOUR  = 2'd2,
    SET_MIN   = 2'd3
  } disp_state_e;

  localparam int DEF_DEBOUNCE_MS = 20;
  localparam int DEF_LONG_MS     = 1000;
  localparam int DEF_REPEAT_MS   = 200;
  localparam int DEF_TIMEOUT_MS  = 10000;
  localparam int DEF_BLINK_MS    = 250;

  function automatic logic is_set_state(disp_state_e s);
    return (s == SET_HOUR) || (s == SET_MIN);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner for one active-low front-panel key.
// Two-flop synchronizer, then a debounce counter: the debounced level only
// follows the synchronized key after DEBOUNCE_MS consecutive differing samples.
// Ports:
//   clk_i    : 1 kHz clock
//   rst_ni   : async active-low reset (level = released)
//   key_n_i  : raw key, active-low, asynchronous
//   level_o  : debounced level, 1 = key down
//   press_o  : one-cycle pulse on the debounced key-down transition
module key_debounce
  import disp_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  // Synchronizer stages hold the key in "down = 1" polarity.
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;
  logic          lvl_q, lvl_dly_q, press_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync1_q <= ~key_n_i;
      sync2_q <= sync1_q;
      // Any sample that agrees with the current level restarts the count.
      if (sync2_q != lvl_q) begin
        if (cnt_q == CW'(DEBOUNCE_MS - 1)) begin
          lvl_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
      lvl_dly_q <= lvl_q;
      press_q   <= lvl_q & ~lvl_dly_q;
    end
  end

  assign level_o = lvl_q;
  assign press_o = press_q;

endmodule

// File: rtl/disp_mode_ctrl.sv
// Mode controller for the digital clock display: debounces the mode and
// adjust keys and runs the CLOCK -> STOPWATCH -> SET_HOUR -> SET_MIN view/set
// state machine. All outputs are registered.
// Optional feature macro: DISP_MODE_AUTO_REPEAT_EN (auto-repeat of inc_* pulses
// while adjust is held in the set states).
// Ports:
//   CLK_1kHz   : only clock         reset     : async active-low
//   key_mode_n : raw mode key       key_adj_n : raw adjust key (active-low)
//   switch     : 0 clock view, 1 stopwatch view
//   blank_h/m  : blank hour/minute digits
//   inc_hour/min : one-cycle increment pulses
//   sw_run     : stopwatch enable level, sw_clear : one-cycle clear pulse
//   mode       : current state (debug)
module disp_mode_ctrl
  import disp_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int LONG_MS     = DEF_LONG_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS,
  parameter int TIMEOUT_MS  = DEF_TIMEOUT_MS,
  parameter int BLINK_MS    = DEF_BLINK_MS
) (
  input  logic       CLK_1kHz,
  input  logic       reset,
  input  logic       key_mode_n,
  input  logic       key_adj_n,
  output logic       switch,
  output logic       blank_h,
  output logic       blank_m,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       sw_run,
  output logic       sw_clear,
  output logic [1:0] mode
);

  localparam int HW = $clog2(LONG_MS + 1);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);

  logic mode_lvl_unused, mode_ev, adj_lvl, adj_ev;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_mode (
    .clk_i   (CLK_1kHz),
    .rst_ni  (reset),
    .key_n_i (key_mode_n),
    .level_o (mode_lvl_unused),
    .press_o (mode_ev)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key_adj (
    .clk_i   (CLK_1kHz),
    .rst_ni  (reset),
    .key_n_i (key_adj_n),
    .level_o (adj_lvl),
    .press_o (adj_ev)
  );

  disp_state_e   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d, cancel_q, cancel_d;
  logic [TW-1:0] to_q, to_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  logic          switch_q, switch_d, blank_h_q, blank_h_d, blank_m_q, blank_m_d;
  logic          inc_hour_q, inc_hour_d, inc_min_q, inc_min_d;
  logic          sw_run_q, sw_run_d, sw_clear_q, sw_clear_d;
  logic          adj_use, long_hit, rpt_pulse, in_set, expire;

  // Mode wins over a coincident adjust press.
  assign adj_use  = adj_ev & ~mode_ev;
  // First cycle the saturated hold counter is seen; long_q makes it once per hold.
  assign long_hit = adj_lvl & ~cancel_q & ~long_q & ~mode_ev &
                    (hold_q == HW'(LONG_MS));

`ifdef DISP_MODE_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_MS + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic          rep_hit;

  // Repeat period starts counting only after the long-press pulse.
  assign rep_hit = adj_lvl & long_q & ~cancel_q & ~mode_ev &
                   (rep_q == RW'(REPEAT_MS - 1));

  always_comb begin
    rep_d = '0;
    if (adj_lvl && long_q && !cancel_q && !mode_ev && !rep_hit)
      rep_d = rep_q + 1'b1;
  end

  always_ff @(posedge CLK_1kHz or negedge reset) begin
    if (!reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end

  assign rpt_pulse = long_hit | rep_hit;
`else
  localparam int REPEAT_UNUSED = REPEAT_MS;
  assign rpt_pulse = 1'b0;
`endif

  // Hold tracking. A mode press while adjust is down parks the tracker
  // (cancel) until the key is released, so no long/repeat action follows.
  always_comb begin
    hold_d   = hold_q;
    long_d   = long_q;
    cancel_d = cancel_q;
    if (!adj_lvl) begin
      hold_d   = '0;
      long_d   = 1'b0;
      cancel_d = 1'b0;
    end else if (mode_ev) begin
      hold_d   = '0;
      long_d   = 1'b0;
      cancel_d = 1'b1;
    end else if (!cancel_q) begin
      if (hold_q != HW'(LONG_MS)) hold_d = hold_q + 1'b1;
      if (long_hit)               long_d = 1'b1;
    end
  end

  assign in_set = is_set_state(state_q);
  // Timeout beats a coincident mode press; a real adjust action resets it instead.
  assign expire = in_set && (to_q == TW'(TIMEOUT_MS - 1)) && !adj_use && !rpt_pulse;

  always_comb begin
    state_d    = state_q;
    sw_run_d   = sw_run_q;
    sw_clear_d = 1'b0;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    if (expire) begin
      state_d = CLOCK;
    end else if (mode_ev) begin
      case (state_q)
        CLOCK:     state_d = STOPWATCH;
        STOPWATCH: state_d = SET_HOUR;
        SET_HOUR:  state_d = SET_MIN;
        default:   state_d = CLOCK;
      endcase
    end
    case (state_q)
      STOPWATCH: begin
        if (adj_use)              sw_run_d   = ~sw_run_q;
        if (long_hit && !sw_run_q) sw_clear_d = 1'b1;
      end
      SET_HOUR: if (adj_use || rpt_pulse) inc_hour_d = 1'b1;
      SET_MIN:  if (adj_use || rpt_pulse) inc_min_d  = 1'b1;
      default: ;
    endcase
  end

  // Timeout and blink counters restart on every state change.
  always_comb begin
    to_d    = '0;
    blk_d   = '0;
    phase_d = 1'b0;
    if (in_set && state_d == state_q && !(adj_ev || mode_ev || rpt_pulse))
      to_d = to_q + 1'b1;
    if (is_set_state(state_d) && state_d == state_q) begin
      if (blk_q == BW'(BLINK_MS - 1)) begin
        blk_d   = '0;
        phase_d = ~phase_q;
      end else begin
        blk_d   = blk_q + 1'b1;
        phase_d = phase_q;
      end
    end
    switch_d  = (state_d == STOPWATCH);
    blank_h_d = (state_d == SET_HOUR) & phase_d & ~adj_lvl;
    blank_m_d = (state_d == SET_MIN)  & phase_d & ~adj_lvl;
  end

  always_ff @(posedge CLK_1kHz or negedge reset) begin
    if (!reset) begin
      state_q    <= CLOCK;
      hold_q     <= '0;
      long_q     <= 1'b0;
      cancel_q   <= 1'b0;
      to_q       <= '0;
      blk_q      <= '0;
      phase_q    <= 1'b0;
      switch_q   <= 1'b0;
      blank_h_q  <= 1'b0;
      blank_m_q  <= 1'b0;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      sw_run_q   <= 1'b0;
      sw_clear_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      long_q     <= long_d;
      cancel_q   <= cancel_d;
      to_q       <= to_d;
      blk_q      <= blk_d;
      phase_q    <= phase_d;
      switch_q   <= switch_d;
      blank_h_q  <= blank_h_d;
      blank_m_q  <= blank_m_d;
      inc_hour_q <= inc_hour_d;
      inc_min_q  <= inc_min_d;
      sw_run_q   <= sw_run_d;
      sw_clear_q <= sw_clear_d;
    end
  end

  assign switch   = switch_q;
  assign blank_h  = blank_h_q;
  assign blank_m  = blank_m_q;
  assign inc_hour = inc_hour_q;
  assign inc_min  = inc_min_q;
  assign sw_run   = sw_run_q;
  assign sw_clear = sw_clear_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Bench for disp_mode_ctrl with short timing parameters. The expected mode and
// stopwatch run level come from a rule-level model updated per key press;
// latencies and pulse counts are derived arithmetically from the timing rules.
module tb_disp_mode_ctrl;

  localparam int D  = 4;
  localparam int LG = 20;
  localparam int RP = 5;
  localparam int TO = 50;
  localparam int BL = 3;
`ifdef DISP_MODE_AUTO_REPEAT_EN
  localparam int EXP_HOLD_INC = 5;
`else
  localparam int EXP_HOLD_INC = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kmode_n = 1'b1;
  logic       kadj_n = 1'b1;
  logic       sw, bh, bm, ih, im, run, clr;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;
  int n_ih = 0, n_im = 0, n_clr = 0;
  int exp_mode = 0, exp_run = 0;
  int bad, base_h, base_m, base_c, npress, g1, g2;

  always #5 clk = ~clk;

  disp_mode_ctrl #(
    .DEBOUNCE_MS(D), .LONG_MS(LG), .REPEAT_MS(RP), .TIMEOUT_MS(TO), .BLINK_MS(BL)
  ) dut (
    .CLK_1kHz   (clk),
    .reset      (rst_n),
    .key_mode_n (kmode_n),
    .key_adj_n  (kadj_n),
    .switch     (sw),
    .blank_h    (bh),
    .blank_m    (bm),
    .inc_hour   (ih),
    .inc_min    (im),
    .sw_run     (run),
    .sw_clear   (clr),
    .mode       (mode)
  );

  always @(negedge clk) begin
    if (ih  === 1'b1) n_ih++;
    if (im  === 1'b1) n_im++;
    if (clr === 1'b1) n_clr++;
  end

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rule-level model of a press: mode advances the view cycle, adjust toggles
  // the stopwatch run level only in the stopwatch view.
  task automatic press(input bit is_adj, input int hold, input int gap);
    if (is_adj) kadj_n = 1'b0; else kmode_n = 1'b0;
    tick(hold);
    kadj_n  = 1'b1;
    kmode_n = 1'b1;
    tick(gap);
    if (is_adj) begin
      if (exp_mode == 1) exp_run = 1 - exp_run;
    end else begin
      exp_mode = (exp_mode + 1) % 4;
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_mode"},   int'(mode), 0);
    chk({pfx, "_switch"}, int'(sw),   0);
    chk({pfx, "_blank"},  int'({bh, bm}), 0);
    chk({pfx, "_inc"},    int'({ih, im}), 0);
    chk({pfx, "_run"},    int'(run),  0);
    chk({pfx, "_clear"},  int'(clr),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and quiet idle.
    tick(3);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (mode != 0 || sw || bh || bm || ih || im || run || clr) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Bounces shorter than the debounce window are rejected.
    g1 = $urandom_range(1, D - 1);
    g2 = $urandom_range(1, D - 1);
    kmode_n = 1'b0; tick(g1);
    kmode_n = 1'b1; tick(1);
    kmode_n = 1'b0; tick(g2);
    kmode_n = 1'b1; tick(12);
    chk("glitch_mode", int'(mode), 0);

    // Press latency: event after edge 2+D, mode visible one edge later.
    kmode_n = 1'b0;
    tick(2 + D + 1);
    chk("lat_before", int'(mode), 0);
    tick(1);
    chk("lat_mode", int'(mode), 1);
    chk("lat_switch", int'(sw), 1);
    tick(2);
    kmode_n = 1'b1;
    tick(12);
    exp_mode = 1;

    // Stopwatch run toggling with a random number of short presses.
    npress = $urandom_range(1, 4);
    for (int i = 0; i < npress; i++) begin
      press(1'b1, $urandom_range(D + 1, 10), $urandom_range(10, 14));
      chk("sw_run_toggle", int'(run), exp_run);
    end
    chk("sw_no_clear_short", n_clr, 0);
    if (exp_run == 0) press(1'b1, $urandom_range(D + 1, 10), 12);
    press(1'b1, 25, 12);                 // stops the watch, then long hold
    chk("sw_run_stopped", int'(run), exp_run);
    chk("sw_clear_once", n_clr, 1);
    press(1'b1, 25, 12);                 // starts it again: no clear while running
    chk("sw_run_started", int'(run), exp_run);
    chk("sw_clear_running", n_clr, 1);
    chk("sw_switch", int'(sw), 1);

    // Enter SET_HOUR and watch the blink phase from state entry.
    kmode_n = 1'b0;
    tick(2 + D + 2);
    exp_mode = 2;
    chk("sh_mode", int'(mode), exp_mode);
    chk("sh_switch", int'(sw), 0);
    chk("run_background", int'(run), 1);
    bad = 0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) tick(1);
      if (k == 2) kmode_n = 1'b1;
      if (int'(bh) != (k / BL) % 2) bad++;
      if (bm !== 1'b0) bad++;
    end
    chk("blink_h", bad, 0);

    // Hold adjust 40 cycles; digits forced visible while held.
    base_h = n_ih;
    kadj_n = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (k >= 8 && bh !== 1'b0) bad++;
    end
    chk("hold_visible", bad, 0);
    kadj_n  = 1'b1;
    kmode_n = 1'b0;                      // straight on to SET_MIN
    tick(2 + D + 2);
    kmode_n = 1'b1;
    exp_mode = 3;
    chk("hold_inc_hour", n_ih - base_h, EXP_HOLD_INC);
    chk("sm_mode", int'(mode), exp_mode);

    // SET_MIN: blink on minutes, then idle timeout exactly TO cycles after entry.
    base_m = n_im;
    bad = 0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) tick(1);
      if (int'(bm) != (k / BL) % 2) bad++;
      if (bh !== 1'b0) bad++;
    end
    chk("blink_m", bad, 0);
    tick(TO - 1 - 17);
    chk("to_not_yet", int'(mode), 3);
    tick(1);
    exp_mode = 0;
    chk("to_expire", int'(mode), exp_mode);
    chk("to_no_inc", n_im - base_m, 0);

    // Back to SET_MIN, then mode and adjust pressed together.
    for (int i = 0; i < 3; i++) press(1'b0, $urandom_range(D + 1, 8), 12);
    chk("sm2_mode", int'(mode), exp_mode);
    base_m = n_im;
    base_h = n_ih;
    kmode_n = 1'b0;
    kadj_n  = 1'b0;
    tick($urandom_range(D + 1, 8));
    kmode_n = 1'b1;
    kadj_n  = 1'b1;
    tick(12);
    exp_mode = 0;
    chk("simul_mode", int'(mode), exp_mode);
    chk("simul_no_inc", (n_im - base_m) + (n_ih - base_h), 0);
    chk("simul_run_kept", int'(run), 1);

    // Reset while adjust is held in SET_HOUR.
    for (int i = 0; i < 2; i++) press(1'b0, $urandom_range(D + 1, 8), 12);
    chk("rh_mode", int'(mode), exp_mode);
    kadj_n = 1'b0;
    tick(15);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    tick(3);
    rst_n = 1'b1;
    tick(10);
    kadj_n = 1'b1;
    base_h = n_ih;
    base_m = n_im;
    base_c = n_clr;
    tick(60);
    chk("post_rst_pulses", (n_ih - base_h) + (n_im - base_m) + (n_clr - base_c), 0);
    chk("post_rst_mode", int'(mode), 0);
    chk("post_rst_run", int'(run), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_mode_ctrl.md
# disp_mode_ctrl

Mode controller for the digital clock display. It debounces the two front-panel keys and runs the view/set state machine. It drives the display scanner's view select (`switch`), the digit-blank flags, the time-adjust increment pulses, and the stopwatch run/clear controls. It sits between the raw keys and the display scanner, the timekeeping counters and the stopwatch counters.

## Interface
Parameters (all in `CLK_1kHz` cycles, i.e. milliseconds):
- DEBOUNCE_MS, 20, input must be stable this long before its debounced level changes
- LONG_MS, 1000, hold time that counts as a long press
- REPEAT_MS, 200, auto-repeat period after a long press
- TIMEOUT_MS, 10000, idle time in a set state before returning to clock view
- BLINK_MS, 250, half-period of the blink phase

Ports:
- CLK_1kHz  input  1  the only clock; all logic is on its rising edge
- reset  input  1  asynchronous, active-low; clears all state
- key_mode_n  input  1  raw mode key, active-low, asynchronous to the clock
- key_adj_n  input  1  raw adjust key, active-low, asynchronous to the clock
- switch  output  1  scanner view select: 0 = clock view, 1 = stopwatch view
- blank_h  output  1  when 1, the scanner blanks the hour digits
- blank_m  output  1  when 1, the scanner blanks the minute digits
- inc_hour  output  1  one-cycle pulse: hour counter +1
- inc_min  output  1  one-cycle pulse: minute counter +1
- sw_run  output  1  level: stopwatch counting enabled
- sw_clear  output  1  one-cycle pulse: stopwatch counters to zero
- mode  output  2  current state, for debug

## Operation
- Key path, per key:
  - Two-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_MS consecutive equal samples that differ from it.
  - A press event is a one-cycle pulse on the debounced 0→1 transition (key down).
- FSM states: CLOCK=0, STOPWATCH=1, SET_HOUR=2, SET_MIN=3.
  - Reset state is CLOCK.
  - A mode event advances CLOCK→STOPWATCH→SET_HOUR→SET_MIN→CLOCK.
- CLOCK: `switch`=0, no blanking, adjust events are ignored.
- STOPWATCH: `switch`=1.
  - Adjust event toggles `sw_run`.
  - Adjust held ≥ LONG_MS while `sw_run`=0 gives one `sw_clear` pulse per hold.
  - `sw_run` keeps its value when leaving STOPWATCH, so the stopwatch runs in the background.
- SET_HOUR / SET_MIN: `switch`=0.
  - An adjust event produces one `inc_hour` / `inc_min` pulse.
  - The selected digits blink: `blank_h` (or `blank_m`) = blink phase. The phase toggles every BLINK_MS; the phase counter is cleared on state entry, so the digits start visible.
  - The digits are forced visible (blank=0) while adjust is debounced-down.
- Timeout:
  - The counter runs only in SET_HOUR / SET_MIN.
  - It is cleared by any press event and by state entry.
  - When it reaches TIMEOUT_MS the FSM goes to CLOCK.
- Simultaneous events:
  - Mode and adjust events in the same cycle: mode wins and the adjust event is dropped.
  - A mode event cancels any hold/repeat tracking.
  - Timeout and a mode event in the same cycle: go to CLOCK.
- Hold counter:
  - Counts while adjust is debounced-down and saturates at LONG_MS.
  - Cleared on release.
  - Its width is sized for the maximum parameter value.

## Timing
- Reset values: `switch`=0, `blank_h`=`blank_m`=0, `inc_hour`=`inc_min`=0, `sw_run`=0, `sw_clear`=0, `mode`=0. Debounced levels = released; all counters = 0.
- Press latency: the raw key goes low before edge 0. The event pulse is high in the cycle after edge 2+DEBOUNCE_MS, unchanged throughout.
- Glitch rejection: a raw bounce shorter than DEBOUNCE_MS cycles produces no event.
- Outputs are registered.
  - `mode`, `switch` and the blank flags update one cycle after the event.
  - The `inc_*` and `sw_clear` pulses are high exactly one cycle, one cycle after their trigger.
- Long press: `sw_clear` pulses in the cycle after the hold counter reaches LONG_MS.
- A reset assertion mid-hold or mid-set returns everything to reset values immediately. No pulse is emitted during or after reset until a new debounced press.

## Configuration
- Macro: DISP_MODE_AUTO_REPEAT_EN.
- Defined: in SET_HOUR / SET_MIN, holding adjust ≥ LONG_MS gives an additional `inc_*` pulse at LONG_MS. After that, one pulse every REPEAT_MS until release. Each repeat pulse also clears the timeout counter.
- Undefined: exactly one `inc_*` pulse per press regardless of hold time; the repeat counter is not built.
- STOPWATCH long-press clear is unaffected either way.

## Structure
- Shared package `disp_pkg`:
  - state encoding constants (CLOCK, STOPWATCH, SET_HOUR, SET_MIN)
  - default timing constants (20/1000/200/10000/250)
- Sub-module `key_debounce` (parameter DEBOUNCE_MS):
  - contains the synchronizer, debounce counter and press-edge detect
  - outputs the debounced level and the press pulse
  - instantiated twice

## Test plan
Run with DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, TIMEOUT_MS=50, BLINK_MS=3.
- Reset released, no keys → `mode`=0, `switch`=0, all pulses 0 for 100 cycles.
- `key_mode_n` low for 2 cycles, high, low for 2 → no event. Then low held → `mode`=1 and `switch`=1, with the event pulse in the cycle after edge 6 (2+DEBOUNCE_MS).
- In STOPWATCH, adjust press → `sw_run`=1. Second press → `sw_run`=0. Hold 25 cycles → exactly one `sw_clear`.
- SET_HOUR, hold adjust 40 cycles:
  - with the macro: `inc_hour` pulses at press, +20, then every 5 cycles (5 pulses total);
  - without the macro: 1 pulse.
- SET_MIN, idle 50 cycles → `mode`=0. Mode and adjust press in the same cycle in SET_MIN → `mode`=0, no `inc_min`.
- In SET_HOUR: `blank_h` toggles every 3 cycles and `blank_m` stays 0. Assert reset while adjust is held → all outputs are at reset values; no pulse appears after release.
